// File: rtl/acsi_cmd_queue_if.sv
// ACSI command queue bus bundle: CPU register port, IO-controller
// command/completion port and status outputs.
interface acsi_cmd_queue_if #(
    parameter int TARGETS = 8
);
    logic               clk_en;
    logic [TARGETS-1:0] enable;
    logic [1:0]         cpu_addr;
    logic               cpu_sel;
    logic               cpu_rw;
    logic [7:0]         cpu_din;
    logic [7:0]         cpu_dout;
    logic               irq;
    logic               cmd_valid;
    logic [2:0]         cmd_target;
    logic [4:0]         cmd_len;
    logic [3:0]         cmd_sel;
    logic [7:0]         cmd_byte;
    logic               dma_ack;
    logic               dma_nak;
    logic [7:0]         dma_status;
    logic               overflow;

    modport master (
        output clk_en, enable, cpu_addr, cpu_sel, cpu_rw, cpu_din,
               cmd_sel, dma_ack, dma_nak, dma_status,
        input  cpu_dout, irq, cmd_valid, cmd_target, cmd_len, cmd_byte, overflow
    );

    modport slave (
        input  clk_en, enable, cpu_addr, cpu_sel, cpu_rw, cpu_din,
               cmd_sel, dma_ack, dma_nak, dma_status,
        output cpu_dout, irq, cmd_valid, cmd_target, cmd_len, cmd_byte, overflow
    );
endinterface

// File: rtl/acsi_cmd_queue.sv
// ACSI command front-end: captures CPU-written command blocks per target,
// queues completed commands for the IO controller and returns its status.
module acsi_cmd_queue #(
    parameter int TARGETS = 8,
    parameter int QDEPTH  = 2
) (
    input  logic            clk,
    input  logic            reset,
    acsi_cmd_queue_if.slave bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ICD} state_t;

    state_t           state_q, state_d;
    logic [2:0]       target_q, target_d;
    logic [4:0]       count_q, count_d;
    logic [15:0][7:0] buf_q, buf_d;
    logic             irq_q, irq_d;
    logic [7:0]       dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;

    logic [2:0]       mem_target_q [QDEPTH];
    logic [4:0]       mem_len_q    [QDEPTH];
    logic [15:0][7:0] mem_bytes_q  [QDEPTH];

    logic       wr_cmd, wr_data, cpu_clr;
    logic       en_target, is_icd, last_byte;
    logic       fifo_valid, fifo_full, pop, ack_pop, push, irq_set;
    logic [7:0] en_pad;
    logic [4:0] cur_len;
    logic       unused_addr;

    // Total command length implied by the opcode byte.
    function automatic logic [4:0] cmd_length(input logic [7:0] op);
        if (op <= 8'h1f)                      return 5'd6;
        else if (op <= 8'h5f)                 return 5'd10;
        else if (op >= 8'h80 && op <= 8'h9f)  return 5'd16;
        else                                  return 5'd12;
    endfunction

    // Pad the enable vector to all 8 IDs; IDs beyond TARGETS read as disabled.
    always_comb begin
        en_pad                = '0;
        en_pad[TARGETS-1:0]   = bus.enable;
    end

    assign unused_addr = bus.cpu_addr[1];
    assign wr_cmd      = bus.cpu_sel && !bus.cpu_rw && bus.clk_en && !bus.cpu_addr[0];
    assign wr_data     = bus.cpu_sel && !bus.cpu_rw && bus.clk_en &&  bus.cpu_addr[0];
    assign cpu_clr     = bus.cpu_sel && bus.clk_en;
    assign en_target   = en_pad[bus.cpu_din[7:5]];
    assign is_icd      = (bus.cpu_din[4:0] == 5'h1f);
    assign cur_len     = cmd_length(buf_q[0]);
    assign last_byte   = (count_q + 5'd1) >= cur_len;
    assign fifo_valid  = (occ_q != '0);
    assign fifo_full   = (occ_q == CW'(QDEPTH));
    assign pop         = fifo_valid && (bus.dma_ack || bus.dma_nak);
    assign ack_pop     = fifo_valid && bus.dma_ack;

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Capture FSM next state: a command-byte write restarts from any state.
    always_comb begin
        state_d = state_q;
        if (wr_cmd) begin
            if (!en_target)  state_d = S_IDLE;
            else if (is_icd) state_d = S_ICD;
            else             state_d = S_COLLECT;
        end else if (wr_data) begin
            case (state_q)
                S_ICD:     state_d = S_COLLECT;
                S_COLLECT: if (last_byte) state_d = S_IDLE;
                default:   state_d = state_q;
            endcase
        end
    end

    // Capture FSM outputs: byte buffer, byte count, irq request, FIFO push.
    always_comb begin
        target_d   = target_q;
        count_d    = count_q;
        buf_d      = buf_q;
        irq_set    = 1'b0;
        push       = 1'b0;
        overflow_d = overflow_q;
        if (wr_cmd) begin
            target_d = bus.cpu_din[7:5];
            count_d  = '0;
            if (en_target && !is_icd) begin
                buf_d[0] = {3'b000, bus.cpu_din[4:0]};
                count_d  = 5'd1;
                irq_set  = 1'b1;
            end
        end else if (wr_data && state_q == S_ICD) begin
            buf_d[0] = bus.cpu_din;
            count_d  = 5'd1;
            irq_set  = 1'b1;
        end else if (wr_data && state_q == S_COLLECT) begin
            buf_d[count_q[3:0]] = bus.cpu_din;
            count_d             = count_q + 5'd1;
            if (!last_byte)              irq_set    = 1'b1;
            else if (!fifo_full || pop)  push       = 1'b1;
            else                         overflow_d = 1'b1;
        end
        // A completion ack wins over a simultaneous CPU clear.
        if (irq_set || ack_pop) irq_d = 1'b1;
        else if (cpu_clr)       irq_d = 1'b0;
        else                    irq_d = irq_q;
    end

    // FIFO pointers, occupancy and completion status.
    always_comb begin
        dout_d   = ack_pop ? bus.dma_status : dout_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q   <= '0;
            count_q    <= '0;
            buf_q      <= '0;
            irq_q      <= 1'b0;
            dout_q     <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            target_q   <= target_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
            irq_q      <= irq_d;
            dout_q     <= dout_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_target_q[wr_ptr_q] <= target_q;
            mem_len_q[wr_ptr_q]    <= cur_len;
            mem_bytes_q[wr_ptr_q]  <= buf_d;
        end
    end

    assign bus.cpu_dout   = dout_q;
    assign bus.irq        = irq_q;
    assign bus.overflow   = overflow_q;
    assign bus.cmd_valid  = fifo_valid;
    assign bus.cmd_target = fifo_valid ? mem_target_q[rd_ptr_q] : '0;
    assign bus.cmd_len    = fifo_valid ? mem_len_q[rd_ptr_q] : '0;
    assign bus.cmd_byte   = fifo_valid ? mem_bytes_q[rd_ptr_q][bus.cmd_sel] : '0;
endmodule

// File: tb/tb_acsi_cmd_queue.sv
// Bench for acsi_cmd_queue: directed scenarios with literal expectations
// plus randomized traffic, all checked against a queue-based model.
module tb_acsi_cmd_queue;
    localparam int TARGETS = 8;
    localparam int QDEPTH  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    acsi_cmd_queue_if #(.TARGETS(TARGETS)) bus();
    acsi_cmd_queue #(.TARGETS(TARGETS), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [2:0]       t;
        logic [4:0]       len;
        logic [15:0][7:0] b;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] part[$];
    int         m_mode = 0;          // 0 idle, 1 collecting, 2 awaiting ICD opcode
    logic [2:0] m_tgt  = '0;
    logic       m_irq  = 1'b0;
    logic [7:0] m_dout = '0;
    logic       m_ovf  = 1'b0;

    function automatic logic [4:0] spec_len(input logic [7:0] op);
        if (op < 8'h20) return 5'd6;
        if (op < 8'h60) return 5'd10;
        if (op >= 8'h80 && op < 8'ha0) return 5'd16;
        return 5'd12;
    endfunction

    always @(posedge clk) begin
        bit   wr, set_irq, do_pop, do_ack, have_e;
        ent_t e;
        if (reset) begin
            mq.delete();
            part.delete();
            m_mode = 0;
            m_tgt  = '0;
            m_irq  = 1'b0;
            m_dout = '0;
            m_ovf  = 1'b0;
        end else begin
            wr      = bus.cpu_sel && !bus.cpu_rw && bus.clk_en;
            do_pop  = (mq.size() > 0) && (bus.dma_ack || bus.dma_nak);
            do_ack  = (mq.size() > 0) && bus.dma_ack;
            set_irq = 1'b0;
            have_e  = 1'b0;
            e       = '0;
            if (wr && !bus.cpu_addr[0]) begin
                m_tgt = bus.cpu_din[7:5];
                part.delete();
                if (int'(m_tgt) >= TARGETS || !bus.enable[m_tgt]) m_mode = 0;
                else if (bus.cpu_din[4:0] == 5'h1f) m_mode = 2;
                else begin
                    part.push_back({3'b000, bus.cpu_din[4:0]});
                    m_mode  = 1;
                    set_irq = 1'b1;
                end
            end else if (wr) begin
                if (m_mode == 2) begin
                    part.push_back(bus.cpu_din);
                    m_mode  = 1;
                    set_irq = 1'b1;
                end else if (m_mode == 1) begin
                    part.push_back(bus.cpu_din);
                    if (part.size() < int'(spec_len(part[0]))) set_irq = 1'b1;
                    else begin
                        e.t   = m_tgt;
                        e.len = spec_len(part[0]);
                        foreach (part[i]) e.b[i] = part[i];
                        have_e = 1'b1;
                        part.delete();
                        m_mode = 0;
                    end
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (do_ack) begin
                m_dout  = bus.dma_status;
                set_irq = 1'b1;
            end
            if (have_e) begin
                if (mq.size() < QDEPTH) mq.push_back(e);
                else m_ovf = 1'b1;
            end
            if (set_irq) m_irq = 1'b1;
            else if (bus.cpu_sel && bus.clk_en) m_irq = 1'b0;
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin
        if (armed) begin
            check("irq", bus.irq, m_irq);
            check("cpu_dout", bus.cpu_dout, m_dout);
            check("overflow", bus.overflow, m_ovf);
            check("cmd_valid", bus.cmd_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("cmd_target", bus.cmd_target, mq[0].t);
                check("cmd_len", bus.cmd_len, mq[0].len);
                if (bus.cmd_sel < mq[0].len)
                    check("cmd_byte", bus.cmd_byte, mq[0].b[bus.cmd_sel]);
            end else begin
                check("cmd_byte_empty", bus.cmd_byte, 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        bus.cpu_sel  = 1'b1;
        bus.cpu_rw   = 1'b0;
        bus.cpu_addr = {1'b0, a0};
        bus.cpu_din  = d;
        tick();
        bus.cpu_sel  = 1'b0;
    endtask

    task automatic rd();
        bus.cpu_sel = 1'b1;
        bus.cpu_rw  = 1'b1;
        tick();
        bus.cpu_sel = 1'b0;
        bus.cpu_rw  = 1'b0;
    endtask

    task automatic ack(input logic [7:0] s);
        bus.dma_ack    = 1'b1;
        bus.dma_status = s;
        tick();
        bus.dma_ack    = 1'b0;
    endtask

    task automatic send6(input logic [7:0] hdr);
        wr(1'b0, hdr);
        for (int i = 0; i < 5; i++) wr(1'b1, 8'(i + 1));
    endtask

    task automatic head_byte(input string name, input logic [3:0] idx, input logic [7:0] exp);
        bus.cmd_sel = idx;
        #1;
        check(name, bus.cmd_byte, exp);
    endtask

    initial begin
        logic [7:0] t1_data [4];
        int         r;
        logic [2:0] t;
        logic [4:0] lo;

        t1_data = '{8'h00, 8'h00, 8'h01, 8'h01};
        bus.clk_en     = 1'b1;
        bus.enable     = 8'hF7;   // target 3 disabled
        bus.cpu_addr   = '0;
        bus.cpu_sel    = 1'b0;
        bus.cpu_rw     = 1'b0;
        bus.cpu_din    = '0;
        bus.cmd_sel    = '0;
        bus.dma_ack    = 1'b0;
        bus.dma_nak    = 1'b0;
        bus.dma_status = '0;

        tick();
        armed = 1'b1;
        reset = 1'b0;
        check("rst_irq", bus.irq, 0);
        check("rst_dout", bus.cpu_dout, 0);
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_ovf", bus.overflow, 0);

        // 6-byte command on target 0
        wr(1'b0, 8'h08);
        check("t1_irq_b0", bus.irq, 1);
        rd();
        check("t1_irq_clr", bus.irq, 0);
        for (int i = 0; i < 4; i++) begin
            wr(1'b1, t1_data[i]);
            check("t1_irq_mid", bus.irq, 1);
        end
        wr(1'b1, 8'h00);
        check("t1_irq_last", bus.irq, 0);
        check("t1_valid", bus.cmd_valid, 1);
        check("t1_len", bus.cmd_len, 6);
        check("t1_tgt", bus.cmd_target, 0);
        head_byte("t1_byte0", 4'd0, 8'h08);
        head_byte("t1_byte3", 4'd3, 8'h01);
        ack(8'h02);
        check("t1_ack_irq", bus.irq, 1);
        check("t1_ack_dout", bus.cpu_dout, 8'h02);
        check("t1_ack_valid", bus.cmd_valid, 0);

        // ICD-prefixed 10-byte command
        rd();
        wr(1'b0, 8'h1f);
        check("t2_irq_prefix", bus.irq, 0);
        wr(1'b1, 8'h25);
        check("t2_irq_op", bus.irq, 1);
        for (int i = 0; i < 9; i++) wr(1'b1, 8'(i + 16));
        check("t2_valid", bus.cmd_valid, 1);
        check("t2_len", bus.cmd_len, 10);
        head_byte("t2_byte0", 4'd0, 8'h25);
        head_byte("t2_byte9", 4'd9, 8'h18);

        // nak the ICD entry, then a command to disabled target 3
        rd();
        bus.dma_nak = 1'b1;
        tick();
        bus.dma_nak = 1'b0;
        check("t3_nak_valid", bus.cmd_valid, 0);
        check("t3_nak_irq", bus.irq, 0);
        check("t3_nak_dout", bus.cpu_dout, 8'h02);
        send6(8'h68);
        check("t3_dis_irq", bus.irq, 0);
        check("t3_dis_valid", bus.cmd_valid, 0);

        // overflow with QDEPTH=2
        send6(8'h28);
        send6(8'h48);
        send6(8'h88);
        check("t4_ovf", bus.overflow, 1);
        check("t4_tgt_a", bus.cmd_target, 1);
        ack(8'h00);
        check("t4_tgt_b", bus.cmd_target, 2);
        ack(8'h00);
        check("t4_drained", bus.cmd_valid, 0);

        // abort a partial command
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_ovf_reset", bus.overflow, 0);
        wr(1'b0, 8'h08);
        wr(1'b1, 8'hAA);
        wr(1'b1, 8'hBB);
        send6(8'h20);
        check("t5_valid", bus.cmd_valid, 1);
        check("t5_tgt", bus.cmd_target, 1);
        head_byte("t5_byte0", 4'd0, 8'h00);
        ack(8'h00);
        check("t5_one_entry", bus.cmd_valid, 0);

        // last byte into a full FIFO while the head is acked
        send6(8'h28);
        send6(8'h48);
        wr(1'b0, 8'h88);
        for (int i = 0; i < 4; i++) wr(1'b1, 8'(i + 1));
        bus.cpu_sel    = 1'b1;
        bus.cpu_rw     = 1'b0;
        bus.cpu_addr   = 2'b01;
        bus.cpu_din    = 8'h77;
        bus.dma_ack    = 1'b1;
        bus.dma_status = 8'h55;
        tick();
        bus.cpu_sel = 1'b0;
        bus.dma_ack = 1'b0;
        check("t6_irq", bus.irq, 1);
        check("t6_ovf", bus.overflow, 0);
        check("t6_dout", bus.cpu_dout, 8'h55);
        check("t6_tgt", bus.cmd_target, 2);
        ack(8'h00);
        check("t6_tgt3", bus.cmd_target, 4);
        head_byte("t6_byte5", 4'd5, 8'h77);
        ack(8'h00);
        check("t6_empty", bus.cmd_valid, 0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) bus.enable = 8'($urandom) | 8'($urandom);
            reset          = (n == 2000);
            bus.clk_en     = ($urandom_range(0, 9) != 0);
            bus.cpu_sel    = 1'b0;
            bus.cpu_rw     = 1'b0;
            bus.cpu_addr   = {1'($urandom), 1'b0};
            bus.cpu_din    = 8'($urandom);
            r = $urandom_range(0, 99);
            if (r < 4) begin
                t  = 3'($urandom);
                lo = ($urandom_range(0, 4) == 0) ? 5'h1f : 5'($urandom);
                bus.cpu_sel = 1'b1;
                bus.cpu_din = {t, lo};
            end else if (r < 70) begin
                bus.cpu_sel     = 1'b1;
                bus.cpu_addr[0] = 1'b1;
            end else if (r < 78) begin
                bus.cpu_sel = 1'b1;
                bus.cpu_rw  = 1'b1;
            end
            bus.dma_ack    = ($urandom_range(0, 9) == 0);
            bus.dma_nak    = ($urandom_range(0, 14) == 0);
            bus.dma_status = 8'($urandom);
            bus.cmd_sel    = 4'($urandom);
            tick();
        end
        reset       = 1'b0;
        bus.cpu_sel = 1'b0;
        bus.dma_ack = 1'b0;
        bus.dma_nak = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
